// File: rtl/yildiz_io_port.sv
// ---------------------------------------------------------------------------
// yildiz_io_port
//   Device-side end of the YildizCPU16 INPR/OUTPR character I/O interface.
//   CPU OUT writes are queued in a small first-word-fall-through TX FIFO and
//   drained to an external valid/ready byte sink. Bytes from an external
//   valid/ready source are captured into the INPR holding register. The
//   FGI/FGO flags polled by the CPU are derived from that state.
//
//   Optional feature macro: YILDIZ_IO_IRQ_EN
//     defined   -> ien/irq ports exist; irq is registered as
//                  ien & (fgi | tx_fifo_empty)
//     undefined -> no interrupt logic; the CPU polls fgi/fgo.
//
// Parameters
//   TX_DEPTH   TX FIFO entries (power of 2, >= 2)
//   TX_AW      log2(TX_DEPTH)
//
// Ports
//   clkn        in   system clock, rising-edge active
//   rstn        in   asynchronous reset, active-low
//   cpu_outpr   in   byte from CPU OUTPR
//   cpu_out_wr  in   1-cycle OUT strobe
//   fgo         out  TX FIFO not full
//   cpu_inpr    out  INPR holding register
//   cpu_in_rd   in   1-cycle INP strobe, consumes INPR
//   fgi         out  INPR holds an unread byte
//   tx_data     out  head byte of TX FIFO
//   tx_valid    out  TX FIFO non-empty
//   tx_ready    in   sink accepts tx_data
//   rx_data     in   source byte
//   rx_valid    in   rx_data valid
//   rx_ready    out  port can accept a byte (= ~fgi)
//   tx_drop     out  sticky: an OUT write arrived while the FIFO was full
//   ien         in   interrupt enable     (YILDIZ_IO_IRQ_EN only)
//   irq         out  interrupt request    (YILDIZ_IO_IRQ_EN only)
// ---------------------------------------------------------------------------
module yildiz_io_port #(
  parameter int TX_DEPTH = 4,
  parameter int TX_AW    = 2
) (
  input  logic       clkn,
  input  logic       rstn,
  input  logic [7:0] cpu_outpr,
  input  logic       cpu_out_wr,
  output logic       fgo,
  output logic [7:0] cpu_inpr,
  input  logic       cpu_in_rd,
  output logic       fgi,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
`ifdef YILDIZ_IO_IRQ_EN
  input  logic       ien,
  output logic       irq,
`endif
  output logic       tx_drop
);

  localparam logic [TX_AW:0] FULL_CNT = (TX_AW+1)'(TX_DEPTH);

  // ---------------------------------------------------------------- TX FIFO
  logic [7:0]     r_mem [TX_DEPTH];
  logic [TX_AW-1:0] r_wr_ptr;
  logic [TX_AW-1:0] r_rd_ptr;
  logic [TX_AW:0] r_count;
  logic           r_tx_drop;

  logic w_push;
  logic w_pop;

  assign fgo      = (r_count != FULL_CNT);
  assign tx_valid = (r_count != '0);
  // A write while full is lost even if a pop frees a slot in the same cycle:
  // fgo is decided from the registered count only.
  assign w_push   = cpu_out_wr & fgo;
  assign w_pop    = tx_valid & tx_ready;
  // Stale storage is masked while empty so tx_data reads 0 out of reset
  // without having to clear the storage array.
  assign tx_data  = tx_valid ? r_mem[r_rd_ptr] : 8'h00;
  assign tx_drop  = r_tx_drop;

  // NOTE: storage array has no reset -- only pointers/count define validity,
  // which keeps the array as plain RAM-style flops without a reset network.
  always_ff @(posedge clkn) begin
    if (w_push) r_mem[r_wr_ptr] <= cpu_outpr;
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clkn or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_tx_drop <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + TX_AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + TX_AW'(1);
      // Simultaneous push and pop leaves the count unchanged.
      if (w_push && !w_pop)      r_count <= r_count + (TX_AW+1)'(1);
      else if (w_pop && !w_push) r_count <= r_count - (TX_AW+1)'(1);
      if (cpu_out_wr && !fgo) r_tx_drop <= 1'b1;
    end
  end

  // ---------------------------------------------------------------- RX path
  logic [7:0] r_inpr;
  logic       r_fgi;
  logic       w_rx_accept;

  assign rx_ready    = ~r_fgi;
  assign w_rx_accept = rx_valid & ~r_fgi;
  assign cpu_inpr    = r_inpr;
  assign fgi         = r_fgi;

  // Accept only happens with fgi = 0 and clear only with fgi = 1, so the two
  // branches are mutually exclusive in practice.
  always_ff @(posedge clkn or negedge rstn) begin
    if (!rstn) begin
      r_inpr <= 8'h00;
      r_fgi  <= 1'b0;
    end else if (w_rx_accept) begin
      r_inpr <= rx_data;
      r_fgi  <= 1'b1;
    end else if (cpu_in_rd && r_fgi) begin
      r_fgi  <= 1'b0;
    end
  end

`ifdef YILDIZ_IO_IRQ_EN
  // ---------------------------------------------------------------- IRQ
  logic r_irq;

  assign irq = r_irq;

  always_ff @(posedge clkn or negedge rstn) begin
    if (!rstn) r_irq <= 1'b0;
    else       r_irq <= ien & (r_fgi | (r_count == '0));
  end
`endif

endmodule

// File: tb/tb_yildiz_io_port.sv
// ---------------------------------------------------------------------------
// tb_yildiz_io_port
//   Self-checking bench for yildiz_io_port. A behavioural model (byte queue
//   for the TX FIFO, plain flags for INPR/FGI/drop/irq) advances at every
//   rising edge from the same inputs the DUT sees; all outputs are compared
//   on the following falling edge. Literal expectations pin the model at the
//   key points of each scenario. Build with +define+YILDIZ_IO_IRQ_EN to cover
//   the interrupt output as well.
// ---------------------------------------------------------------------------
module tb_yildiz_io_port;

  localparam int DEPTH = 4;

  logic       clkn = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] cpu_outpr = 8'h00;
  logic       cpu_out_wr = 1'b0;
  logic       fgo;
  logic [7:0] cpu_inpr;
  logic       cpu_in_rd = 1'b0;
  logic       fgi;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  logic       tx_drop;
`ifdef YILDIZ_IO_IRQ_EN
  logic       ien = 1'b0;
  logic       irq;
`endif

  yildiz_io_port #(.TX_DEPTH(DEPTH), .TX_AW(2)) dut (
    .clkn       (clkn),
    .rstn       (rstn),
    .cpu_outpr  (cpu_outpr),
    .cpu_out_wr (cpu_out_wr),
    .fgo        (fgo),
    .cpu_inpr   (cpu_inpr),
    .cpu_in_rd  (cpu_in_rd),
    .fgi        (fgi),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
`ifdef YILDIZ_IO_IRQ_EN
    .ien        (ien),
    .irq        (irq),
`endif
    .tx_drop    (tx_drop)
  );

  always #5 clkn = ~clkn;

  // ------------------------------------------------------------ model state
  logic [7:0] m_q[$];
  logic       m_drop;
  logic       m_fgi;
  logic [7:0] m_inpr;
  logic       m_irq;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_drop = 1'b0;
    m_fgi  = 1'b0;
    m_inpr = 8'h00;
    m_irq  = 1'b0;
  endtask

  // One rising edge of the specification's rules, evaluated on pre-edge state.
  task automatic model_step();
    bit full, empty, push, pop;
    full  = (m_q.size() == DEPTH);
    empty = (m_q.size() == 0);
    push  = cpu_out_wr && !full;
    pop   = !empty && tx_ready;
`ifdef YILDIZ_IO_IRQ_EN
    m_irq = ien && (m_fgi || empty);
`endif
    if (cpu_out_wr && full) m_drop = 1'b1;
    if (pop)  void'(m_q.pop_front());
    if (push) m_q.push_back(cpu_outpr);
    if (rx_valid && !m_fgi) begin
      m_inpr = rx_data;
      m_fgi  = 1'b1;
    end else if (cpu_in_rd && m_fgi) begin
      m_fgi = 1'b0;
    end
  endtask

  task automatic compare_all();
    check("fgo",      int'(fgo),      int'(m_q.size() != DEPTH));
    check("tx_valid", int'(tx_valid), int'(m_q.size() != 0));
    if (m_q.size() != 0) check("tx_data", int'(tx_data), int'(m_q[0]));
    check("cpu_inpr", int'(cpu_inpr), int'(m_inpr));
    check("fgi",      int'(fgi),      int'(m_fgi));
    check("rx_ready", int'(rx_ready), int'(!m_fgi));
    check("tx_drop",  int'(tx_drop),  int'(m_drop));
`ifdef YILDIZ_IO_IRQ_EN
    check("irq",      int'(irq),      int'(m_irq));
`endif
  endtask

  // Advance one clock: model steps on the rising edge, outputs compared on
  // the falling edge; the caller then drives the next inputs.
  task automatic cycle();
    @(posedge clkn);
    model_step();
    @(negedge clkn);
    compare_all();
  endtask

  task automatic idle_inputs();
    cpu_out_wr = 1'b0;
    cpu_in_rd  = 1'b0;
    rx_valid   = 1'b0;
    tx_ready   = 1'b0;
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic do_reset();
    #1 rstn = 1'b0;
    #1;
    check("rst_tx_valid", int'(tx_valid), 0);
    check("rst_fgo",      int'(fgo),      1);
    check("rst_fgi",      int'(fgi),      0);
    check("rst_inpr",     int'(cpu_inpr), 0);
    check("rst_tx_drop",  int'(tx_drop),  0);
    check("rst_tx_data",  int'(tx_data),  0);
    check("rst_rx_ready", int'(rx_ready), 1);
    model_reset();
    idle_inputs();
    @(posedge clkn);
    @(negedge clkn);
    compare_all();
    rstn = 1'b1;
  endtask

  task automatic write_byte(input logic [7:0] b, input logic rdy);
    cpu_outpr  = b;
    cpu_out_wr = 1'b1;
    tx_ready   = rdy;
    cycle();
    cpu_out_wr = 1'b0;
    tx_ready   = 1'b0;
  endtask

  initial begin
    logic [7:0] burst [4];
    burst = '{8'h11, 8'h22, 8'h33, 8'h44};
    model_reset();

    // ---- reset from power-up
    @(negedge clkn);
    do_reset();
    cycle();

    // ---- OUT burst with sink stalled, then overflow write
    foreach (burst[i]) write_byte(burst[i], 1'b0);
    check("burst_fgo",     int'(fgo),     0);
    check("burst_tx_data", int'(tx_data), 'h11);
    write_byte(8'h55, 1'b0);
    check("drop_sticky",   int'(tx_drop), 1);

    // ---- drain: head order 11,22,33,44, one per cycle
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_head", int'(tx_data), int'(burst[i]));
      cycle();
      if (i == 0) check("drain_fgo", int'(fgo), 1);
    end
    check("drain_empty", int'(tx_valid), 0);
    tx_ready = 1'b0;

    // ---- pointer wrap: alternate write / pop
    for (int i = 0; i < 6; i++) begin
      write_byte(8'h60 + 8'(i), 1'b0);
      tx_ready = 1'b1;
      check("wrap_head", int'(tx_data), 'h60 + i);
      cycle();
      tx_ready = 1'b0;
    end

    // ---- simultaneous push/pop at count 2, then on a full FIFO
    write_byte(8'hA1, 1'b0);
    write_byte(8'hA2, 1'b0);
    write_byte(8'hA3, 1'b1);   // pops A1, pushes A3: still 2 entries
    check("simul_head", int'(tx_data), 'hA2);
    write_byte(8'hA4, 1'b0);
    write_byte(8'hA5, 1'b0);   // full: A2 A3 A4 A5
    write_byte(8'hA6, 1'b1);   // dropped, A2 popped -> 3 entries
    check("full_simul_fgo",  int'(fgo),     1);
    check("full_simul_head", int'(tx_data), 'hA3);
    tx_ready = 1'b1;
    repeat (3) cycle();
    check("full_simul_cnt3", int'(tx_valid), 0);
    tx_ready = 1'b0;

    // ---- RX capture, back-pressure, consume
    rx_valid = 1'b1;
    rx_data  = 8'hA5;
    cycle();
    check("rx_fgi",   int'(fgi),      1);
    check("rx_inpr",  int'(cpu_inpr), 'hA5);
    check("rx_ready", int'(rx_ready), 0);
    rx_data = 8'h5A;
    repeat (3) cycle();
    check("rx_held", int'(cpu_inpr), 'hA5);
    cpu_in_rd = 1'b1;
    cycle();
    cpu_in_rd = 1'b0;
    check("rx_clear", int'(fgi), 0);
    cycle();
    check("rx_second", int'(cpu_inpr), 'h5A);
    check("rx_second_fgi", int'(fgi), 1);
    rx_valid  = 1'b0;
    cpu_in_rd = 1'b1;
    cycle();
    cpu_in_rd = 1'b0;
    cycle();

`ifdef YILDIZ_IO_IRQ_EN
    // ---- interrupt: empty FIFO, fgi = 0
    ien = 1'b1;
    cycle();
    check("irq_empty", int'(irq), 1);
    write_byte(8'h77, 1'b0);
    cycle();
    check("irq_fall", int'(irq), 0);
    ien = 1'b0;
    rx_valid = 1'b1;
    rx_data  = 8'h33;
    cycle();
    rx_valid = 1'b0;
    cycle();
    check("irq_masked", int'(irq), 0);
`endif

    // ---- randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      cpu_out_wr = ($urandom_range(0, 2) == 0);
      cpu_outpr  = 8'($urandom);
      tx_ready   = ($urandom_range(0, 3) != 0) ? (i % 200 > 60) : 1'b0;
      rx_valid   = ($urandom_range(0, 1) == 1);
      rx_data    = 8'($urandom);
      cpu_in_rd  = ($urandom_range(0, 2) == 0);
`ifdef YILDIZ_IO_IRQ_EN
      if ($urandom_range(0, 15) == 0) ien = ~ien;
`endif
      cycle();
    end
    idle_inputs();
`ifdef YILDIZ_IO_IRQ_EN
    ien = 1'b0;
`endif
    cycle();

    // ---- reset mid-operation: 3 bytes queued and fgi = 1
    do_reset();
    cycle();
    write_byte(8'hC1, 1'b0);
    write_byte(8'hC2, 1'b0);
    cpu_outpr  = 8'hC3;
    cpu_out_wr = 1'b1;
    rx_valid   = 1'b1;
    rx_data    = 8'h99;
    cycle();
    idle_inputs();
    check("pre_rst_valid", int'(tx_valid), 1);
    check("pre_rst_fgi",   int'(fgi),      1);
    do_reset();
    repeat (3) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
